// File: rtl/cpu_pkg.sv
// Shared CPU package: default bus widths, data-memory port indices
// and the arbitration state encoding used by dmem_arbiter.
package cpu_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    typedef enum logic {
        PRI0   = 1'b0,
        FORCE1 = 1'b1
    } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle between the two requesters, dmem_arbiter and data_mem.
// Ports p0_* (MEM stage), p1_* (debug/loader), mem_* (data_mem side).
// slave: arbiter view; master: requesters plus memory view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_gnt;
    logic              p0_rvalid;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_gnt;
    logic              p1_rvalid;
    logic [DATA_W-1:0] p1_rdata;

    logic              mem_r;
    logic              mem_w;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  mem_rdata,
        output p0_gnt, p0_rvalid, p0_rdata,
        output p1_gnt, p1_rvalid, p1_rdata,
        output mem_r, mem_w, mem_addr, mem_wdata
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output mem_rdata,
        input  p0_gnt, p0_rvalid, p0_rdata,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  mem_r, mem_w, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_starve_ctr.sv
// Saturating 4-bit count of consecutive denied port-1 cycles.
// Ports: clk, rst, inc_i, clr_i (clr wins), cnt_o, sat_o (cnt at max).
module dmem_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc_i,
    input  logic       clr_i,
    output logic [3:0] cnt_o,
    output logic       sat_o
);
    localparam logic [3:0] MAXV = 4'(STARVE_MAX);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && cnt_q != MAXV) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign sat_o = (cnt_q == MAXV);
endmodule

// File: rtl/dmem_arbiter.sv
// Shares data_mem between MEM stage (port 0, priority) and debug port 1.
// Ports: clk, rst (async high), bus (dmem_arbiter_if.slave).
module dmem_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = 4
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);
    localparam logic [3:0] SMAX_M1 = 4'(STARVE_MAX - 1);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic              gnt0;
    logic              gnt1;
    logic              mr;
    logic              mw;
    logic [ADDR_W-1:0] maddr;
    logic [DATA_W-1:0] mwdata;
    logic              rd_pend_q;
    logic              rd_pend_d;
    logic              rd_owner_q;
    logic              rd_owner_d;
    logic [3:0]        starve_q;
    logic              starve_sat;
    logic              starve_inc;
    logic              force_go;

    // Grant and memory mux; depends only on req and registered state.
    always_comb begin
        gnt0   = 1'b0;
        gnt1   = 1'b0;
        mr     = 1'b0;
        mw     = 1'b0;
        maddr  = '0;
        mwdata = '0;
        unique case (state_q)
            PRI0: begin
                if (bus.p0_req) gnt0 = 1'b1;
                else if (bus.p1_req) gnt1 = 1'b1;
            end
            FORCE1: begin
                if (bus.p1_req) gnt1 = 1'b1;
                else if (bus.p0_req) gnt0 = 1'b1;
            end
        endcase
        if (gnt0) begin
            mr     = ~bus.p0_we;
            mw     = bus.p0_we;
            maddr  = bus.p0_addr;
            mwdata = bus.p0_wdata;
        end else if (gnt1) begin
            mr     = ~bus.p1_we;
            mw     = bus.p1_we;
            maddr  = bus.p1_addr;
            mwdata = bus.p1_wdata;
        end
    end

    assign starve_inc = bus.p1_req & ~gnt1;

    dmem_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk   (clk),
        .rst   (rst),
        .inc_i (starve_inc),
        .clr_i (~starve_inc),
        .cnt_o (starve_q),
        .sat_o (starve_sat)
    );

    // Counter reaches its maximum on this edge.
    assign force_go = starve_inc & (starve_sat | (starve_q == SMAX_M1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PRI0:   if (force_go) state_d = FORCE1;
            FORCE1: if (gnt1 || !bus.p1_req) state_d = PRI0;
        endcase
    end

    // One read in flight at most: data_mem answers on the next cycle.
    always_comb begin
        rd_pend_d  = mr;
        rd_owner_d = gnt1 ? PORT_DBG : PORT_CPU;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= PRI0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= PORT_CPU;
        end else begin
            state_q    <= state_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign bus.p0_gnt    = gnt0;
    assign bus.p1_gnt    = gnt1;
    assign bus.mem_r     = mr;
    assign bus.mem_w     = mw;
    assign bus.mem_addr  = maddr;
    assign bus.mem_wdata = mwdata;
    assign bus.p0_rvalid = rd_pend_q & (rd_owner_q == PORT_CPU);
    assign bus.p1_rvalid = rd_pend_q & (rd_owner_q == PORT_DBG);
    assign bus.p0_rdata  = bus.mem_rdata;
    assign bus.p1_rdata  = bus.mem_rdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a data_mem model and a
// streak-based reference model of the arbitration rules.
module tb_dmem_arbiter;
    import cpu_pkg::*;

    localparam int SMAX = 4;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // data_mem: one access per cycle, registered read data
    logic [31:0] mem     [0:65535];
    logic [31:0] ref_mem [0:65535];

    always @(posedge clk) begin
        if (bus.mem_w) mem[bus.mem_addr[15:0]] <= bus.mem_wdata;
        if (bus.mem_r) bus.mem_rdata <= mem[bus.mem_addr[15:0]];
    end

    function automatic logic [31:0] init_val(input int i);
        if (i == 2) return 32'd15;
        if (i == 3) return 32'd1024;
        if (i == 4) return 32'd9;
        return 32'(i * 7 + 1);
    endfunction

    typedef struct {
        bit          port;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sbq[$];
    int   pass_cnt = 0;
    int   chk_cnt  = 0;
    int   run      = 0;
    logic [31:0] last_rv_data;
    bit          last_rv_port;

    task automatic check(input string nm, input logic [79:0] act,
                         input logic [79:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d",
                      nm, act, exp, cyc);
    endtask

    // Monitor: pops one expectation per observed read response.
    initial begin
        exp_t e;
        logic v0;
        logic v1;
        forever begin
            @(posedge clk);
            #2;
            v0 = bus.p0_rvalid;
            v1 = bus.p1_rvalid;
            if (v0 && v1) check("rvalid_both", 2'b11, 2'b01);
            if (v0 || v1) begin
                if (sbq.size() == 0) begin
                    check("rvalid_unexpected", {v0, v1}, 2'b00);
                end else begin
                    e = sbq.pop_front();
                    last_rv_port = v1;
                    last_rv_data = v1 ? bus.p1_rdata : bus.p0_rdata;
                    check("rvalid_cycle", 80'(cyc), 80'(e.due));
                    check("rvalid_port", 80'(v1), 80'(e.port));
                    check("rdata", 80'(last_rv_data), 80'(e.data));
                end
            end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
                check("rvalid_missing", 1'b0, 1'b1);
                void'(sbq.pop_front());
            end
        end
    end

    // One bus cycle: drive, compare against model, advance model.
    task automatic step(
        input  bit r0, input bit w0,
        input  logic [31:0] a0, input logic [31:0] d0,
        input  bit r1, input bit w1,
        input  logic [31:0] a1, input logic [31:0] d1,
        input  bit do_rst,
        output bit eg0, output bit eg1,
        output bit ag0, output bit ag1
    );
        bit          forced;
        bit          er;
        bit          ew;
        logic [31:0] ea;
        logic [31:0] ed;
        exp_t        e;
        #1;
        bus.p0_req = r0; bus.p0_we = w0;
        bus.p0_addr = a0; bus.p0_wdata = d0;
        bus.p1_req = r1; bus.p1_we = w1;
        bus.p1_addr = a1; bus.p1_wdata = d1;
        #3;
        forced = (run >= SMAX);
        eg0 = 1'b0; eg1 = 1'b0;
        if (r1 && (forced || !r0)) eg1 = 1'b1;
        else if (r0) eg0 = 1'b1;
        er = 1'b0; ew = 1'b0; ea = '0; ed = '0;
        if (eg0) begin er = !w0; ew = w0; ea = a0; ed = d0; end
        if (eg1) begin er = !w1; ew = w1; ea = a1; ed = d1; end
        ag0 = bus.p0_gnt;
        ag1 = bus.p1_gnt;
        check("grant", {ag0, ag1}, {eg0, eg1});
        check("membus", {bus.mem_r, bus.mem_w, bus.mem_addr, bus.mem_wdata},
              {er, ew, ea, ed});
        check("starve", 80'(dut.starve_q), 80'((run > SMAX) ? SMAX : run));
        if (ew) ref_mem[ea[15:0]] = ed;
        if (do_rst) begin
            #2;
            rst = 1'b1;
            bus.p0_req = 1'b0;
            bus.p1_req = 1'b0;
            run = 0;
        end else begin
            if (er) begin
                e.port = eg1;
                e.data = ref_mem[ea[15:0]];
                e.due  = cyc + 1;
                sbq.push_back(e);
            end
            if (r1 && !eg1) run++;
            else run = 0;
        end
        @(posedge clk);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 15));
        if ($urandom_range(0, 7) == 0) a = a | 32'h0001_0000;
        return a;
    endfunction

    initial begin
        bit g0, g1, a0, a1;
        int first_p1;
        bit p0_at;
        bit pend0, pend1, w0, w1;
        logic [31:0] ad0, ad1, wd0, wd1;

        for (int i = 0; i < 65536; i++) begin
            mem[i]     = init_val(i);
            ref_mem[i] = init_val(i);
        end
        rst = 1'b1;
        bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = 0; bus.p0_wdata = 0;
        bus.p1_req = 0; bus.p1_we = 0; bus.p1_addr = 0; bus.p1_wdata = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rvalid", {bus.p0_rvalid, bus.p1_rvalid}, 2'b00);
        check("reset_grant", {bus.p0_gnt, bus.p1_gnt, bus.mem_r, bus.mem_w},
              4'b0000);
        check("reset_state", 80'(dut.state_q), 80'(PRI0));
        rst = 1'b0;
        @(posedge clk);

        // port-0 read of initial contents
        step(1, 0, 2, 0, 0, 0, 0, 0, 0, g0, g1, a0, a1);
        check("p0_read_gnt", a0, 1'b1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1, a0, a1);
        check("p0_read_data", {last_rv_port, last_rv_data}, {1'b0, 32'd15});

        // port-1 write then read back
        step(0, 0, 0, 0, 1, 1, 100, 77, 0, g0, g1, a0, a1);
        step(0, 0, 0, 0, 1, 0, 100, 0, 0, g0, g1, a0, a1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1, a0, a1);
        check("p1_raw_data", {last_rv_port, last_rv_data}, {1'b1, 32'd77});

        // simultaneous reads: port 0 first
        step(1, 0, 3, 0, 1, 0, 4, 0, 0, g0, g1, a0, a1);
        check("both_first", {a0, a1}, 2'b10);
        step(0, 0, 0, 0, 1, 0, 4, 0, 0, g0, g1, a0, a1);
        check("both_p0_data", {last_rv_port, last_rv_data}, {1'b0, 32'd1024});
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1, a0, a1);
        check("both_p1_data", {last_rv_port, last_rv_data}, {1'b1, 32'd9});

        // starvation under continuous port-0 load
        first_p1 = 0;
        p0_at    = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step(1, 0, 32'(20 + i), 0, first_p1 == 0, 0, 50, 0, 0,
                 g0, g1, a0, a1);
            if (a1 && first_p1 == 0) begin
                first_p1 = i;
                p0_at    = a0;
            end
        end
        check("starve_p1_cycle", 80'(first_p1), 80'(SMAX + 1));
        check("starve_p0_low", p0_at, 1'b0);
        check("starve_cleared", 80'(dut.starve_q), 80'(0));
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1, a0, a1);

        // reset while a port-0 read is outstanding
        step(1, 0, 5, 0, 0, 0, 0, 0, 1, g0, g1, a0, a1);
        repeat (2) begin
            #2;
            check("rst_rvalid", {bus.p0_rvalid, bus.p1_rvalid}, 2'b00);
            @(posedge clk);
        end
        #1;
        rst = 1'b0;
        #1;
        check("rst_state", 80'(dut.state_q), 80'(PRI0));
        check("rst_starve", 80'(dut.starve_q), 80'(0));
        @(posedge clk);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1, a0, a1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1, a0, a1);

        // randomized traffic, requests held until granted
        pend0 = 0; pend1 = 0;
        w0 = 0; w1 = 0; ad0 = 0; ad1 = 0; wd0 = 0; wd1 = 0;
        for (int n = 0; n < 10000; n++) begin
            if (!pend0 && $urandom_range(0, 2) != 0) begin
                pend0 = 1; w0 = 1'($urandom_range(0, 1));
                ad0 = rand_addr(); wd0 = $urandom;
            end
            if (!pend1 && $urandom_range(0, 2) == 0) begin
                pend1 = 1; w1 = 1'($urandom_range(0, 1));
                ad1 = rand_addr(); wd1 = $urandom;
            end
            if (pend1 && $urandom_range(0, 15) == 0) pend1 = 0;
            if (pend0 && $urandom_range(0, 31) == 0) pend0 = 0;
            step(pend0, w0, ad0, wd0, pend1, w1, ad1, wd1, 0,
                 g0, g1, a0, a1);
            if (g0) pend0 = 0;
            if (g1) pend1 = 0;
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1, a0, a1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1, a0, a1);
        #3;
        check("sb_drained", 80'(sbq.size()), 80'(0));

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
